// File: rtl/multi_prd_freq_meter_pkg.sv
// Shared types and constant helpers for the reciprocal multi-period frequency meter.
package multi_prd_freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS,
    ST_DIV,
    ST_CONV,
    ST_FIN
  } state_t;

  // Divider width: wide enough for the tick counter and for the NPRD*TICK_HZ dividend.
  function automatic int calc_w(input int pw, input int nprd, input int tick_hz);
    int need;
    need = $clog2(longint'(nprd) * longint'(tick_hz) + 64'sd1);
    return (pw > need) ? pw : need;
  endfunction

  function automatic logic [31:0] bcd_nines(input int digits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    return r;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/div.sv
// Restoring unsigned divider, one quotient bit per cycle; done_tick_o one cycle after the last step.
// A zero divisor yields an all-ones quotient.
module div #(
  parameter int W    = 8,
  parameter int CBIT = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [W-1:0] dvsr_i,
  input  logic [W-1:0] dvnd_i,
  output logic         done_tick_o,
  output logic [W-1:0] quo_o
);

  logic            busy_q;
  logic [W-1:0]    rh_q, rl_q, d_q;
  logic [CBIT-1:0] n_q;
  logic            done_q;

  logic [W:0]   rem_sh;
  logic         ge;
  logic [W-1:0] rh_d, rl_d;

  always_comb begin
    rem_sh = {rh_q, rl_q[W-1]};
    ge     = (rem_sh >= {1'b0, d_q});
    rh_d   = ge ? W'(rem_sh - {1'b0, d_q}) : rem_sh[W-1:0];
    rl_d   = {rl_q[W-2:0], ge};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      rh_q   <= '0;
      rl_q   <= '0;
      d_q    <= '0;
      n_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start_i) begin
          busy_q <= 1'b1;
          rh_q   <= '0;
          rl_q   <= dvnd_i;
          d_q    <= dvsr_i;
          n_q    <= CBIT'(W);
        end
      end else begin
        rh_q <= rh_d;
        rl_q <= rl_d;
        n_q  <= n_q - 1'b1;
        if (n_q == CBIT'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_tick_o = done_q;
  assign quo_o       = rl_q;

endmodule

// File: rtl/multi_period_counter.sv
// Times NPRD rising edges of async si in prescaled ticks; done_tick_o pulses with t_o or tmo_o.
// Edge detection is 2 synchroniser cycles behind si; the tick count saturates into a timeout.
module multi_period_counter #(
  parameter int DIV_RATIO = 100,
  parameter int NPRD      = 4,
  parameter int PW        = 20
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          si_i,
  output logic          meas_o,
  output logic          done_tick_o,
  output logic          tmo_o,
  output logic [PW-1:0] t_o
);

  localparam int PSW = $clog2(DIV_RATIO);
  localparam int EW  = $clog2(NPRD + 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(DIV_RATIO - 1);
  localparam logic [EW-1:0]  E_LAST  = EW'(NPRD - 1);
  localparam logic [PW-1:0]  T_PRE   = PW'((longint'(1) << PW) - 2);

  logic           meta_q, sync1_q, sync2_q;
  logic           arm_q, meas_q, done_q, tmo_q;
  logic [PSW-1:0] pre_q;
  logic [PW-1:0]  tick_cnt_q, t_q;
  logic [EW-1:0]  edge_cnt_q;

  logic rise, tick, timeout_hit;

  always_comb begin
    rise        = sync1_q & ~sync2_q;
    tick        = (pre_q == PS_LAST);
    timeout_hit = tick && (tick_cnt_q == T_PRE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q     <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      arm_q      <= 1'b0;
      meas_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      pre_q      <= '0;
      tick_cnt_q <= '0;
      t_q        <= '0;
      edge_cnt_q <= '0;
    end else begin
      meta_q  <= si_i;
      sync1_q <= meta_q;
      sync2_q <= sync1_q;
      done_q  <= 1'b0;
      if (start_i) begin
        arm_q      <= 1'b1;
        meas_q     <= 1'b0;
        tmo_q      <= 1'b0;
        pre_q      <= '0;
        tick_cnt_q <= '0;
        edge_cnt_q <= '0;
      end else if (arm_q || meas_q) begin
        pre_q      <= tick ? '0 : pre_q + 1'b1;
        tick_cnt_q <= tick_cnt_q + PW'(tick);
        // A final edge coinciding with the timeout tick still yields a valid T.
        if (meas_q && rise && edge_cnt_q == E_LAST) begin
          meas_q <= 1'b0;
          done_q <= 1'b1;
          t_q    <= tick_cnt_q + PW'(tick);
        end else if (timeout_hit) begin
          arm_q  <= 1'b0;
          meas_q <= 1'b0;
          done_q <= 1'b1;
          tmo_q  <= 1'b1;
        end else if (arm_q && rise) begin
          arm_q      <= 1'b0;
          meas_q     <= 1'b1;
          pre_q      <= '0;
          tick_cnt_q <= '0;
          edge_cnt_q <= '0;
        end else if (meas_q && rise) begin
          edge_cnt_q <= edge_cnt_q + 1'b1;
        end
      end
    end
  end

  assign meas_o      = meas_q;
  assign done_tick_o = done_q;
  assign tmo_o       = tmo_q;
  assign t_o         = t_q;

endmodule

// File: rtl/multi_prd_freq_meter.sv
// Reciprocal frequency meter: freq = NPRD*TICK_HZ / T, committed with packed BCD in one done_tick_o.
// Result latency after the last edge is sync + divide + W-step double-dabble + fin; outputs hold between commits.
module multi_prd_freq_meter
  import multi_prd_freq_meter_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1_000_000,
  parameter int NPRD    = 4,
  parameter int PW      = 20,
  parameter int DIGITS  = 4,
  localparam int W      = calc_w(PW, NPRD, TICK_HZ)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                cont_i,
  input  logic                si_i,
  output logic                ready_o,
  output logic                done_tick_o,
  output logic                ovf_o,
  output logic                tmo_o,
  output logic [W-1:0]        freq_o,
  output logic [4*DIGITS-1:0] bcd_o
);

  localparam int BW   = 4 * DIGITS;
  localparam int CBIT = $clog2(W) + 1;
  localparam logic [W-1:0]  DVND  = W'(longint'(NPRD) * longint'(TICK_HZ));
  localparam logic [63:0]   LIMIT = pow10(DIGITS);
  localparam logic [31:0]   NINES = bcd_nines(DIGITS);

  state_t          state_q;
  logic            ready_q, done_q, ovf_q, tmo_q;
  logic [W-1:0]    freq_q;
  logic [BW-1:0]   bcd_q;
  logic            res_ovf_q, res_tmo_q;
  logic [W-1:0]    res_freq_q;
  logic [BW-1:0]   res_bcd_q;
  logic            cnt_start_q, div_start_q;
  logic [W-1:0]    t_q, bin_q;
  logic [BW-1:0]   dd_q;
  logic [CBIT-1:0] sh_cnt_q;

  logic          cnt_meas, cnt_done, cnt_tmo;
  logic [PW-1:0] cnt_t;
  logic          div_done;
  logic [W-1:0]  div_quo;
  logic          quo_big;
  logic [BW-1:0] dd_adj, dd_d;
  logic [3:0]    dig;

  multi_period_counter #(
    .DIV_RATIO(CLK_HZ / TICK_HZ),
    .NPRD     (NPRD),
    .PW       (PW)
  ) u_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (cnt_start_q),
    .si_i       (si_i),
    .meas_o     (cnt_meas),
    .done_tick_o(cnt_done),
    .tmo_o      (cnt_tmo),
    .t_o        (cnt_t)
  );

  div #(
    .W   (W),
    .CBIT(CBIT)
  ) u_div (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (div_start_q),
    .dvsr_i     (t_q),
    .dvnd_i     (DVND),
    .done_tick_o(div_done),
    .quo_o      (div_quo)
  );

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    dd_adj = '0;
    dig    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = dd_q[4*i +: 4];
      dd_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    dd_d    = BW'({dd_adj, bin_q[W-1]});
    quo_big = (64'(div_quo) >= LIMIT);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      freq_q      <= '0;
      bcd_q       <= '0;
      res_ovf_q   <= 1'b0;
      res_tmo_q   <= 1'b0;
      res_freq_q  <= '0;
      res_bcd_q   <= '0;
      cnt_start_q <= 1'b0;
      div_start_q <= 1'b0;
      t_q         <= '0;
      bin_q       <= '0;
      dd_q        <= '0;
      sh_cnt_q    <= '0;
    end else begin
      cnt_start_q <= 1'b0;
      div_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i || cont_i) begin
            state_q     <= ST_ARM;
            ready_q     <= 1'b0;
            cnt_start_q <= 1'b1;
          end
        end
        ST_ARM, ST_MEAS: begin
          if (cnt_done) begin
            if (cnt_tmo) begin
              res_freq_q <= '0;
              res_bcd_q  <= '0;
              res_ovf_q  <= 1'b0;
              res_tmo_q  <= 1'b1;
              state_q    <= ST_FIN;
            end else begin
              t_q         <= W'(cnt_t);
              div_start_q <= (cnt_t != '0);
              state_q     <= ST_DIV;
            end
          end else if (cnt_meas) begin
            state_q <= ST_MEAS;
          end
        end
        ST_DIV: begin
          if (t_q == '0) begin
            res_freq_q <= '1;
            res_bcd_q  <= NINES[BW-1:0];
            res_ovf_q  <= 1'b1;
            res_tmo_q  <= 1'b0;
            state_q    <= ST_FIN;
          end else if (div_done) begin
            res_freq_q <= div_quo;
            res_tmo_q  <= 1'b0;
            if (quo_big) begin
              res_bcd_q <= NINES[BW-1:0];
              res_ovf_q <= 1'b1;
              state_q   <= ST_FIN;
            end else begin
              bin_q    <= div_quo;
              dd_q     <= '0;
              sh_cnt_q <= '0;
              state_q  <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          bin_q    <= {bin_q[W-2:0], 1'b0};
          dd_q     <= dd_d;
          sh_cnt_q <= sh_cnt_q + 1'b1;
          if (sh_cnt_q == CBIT'(W - 1)) begin
            res_bcd_q <= dd_d;
            res_ovf_q <= 1'b0;
            state_q   <= ST_FIN;
          end
        end
        ST_FIN: begin
          freq_q <= res_freq_q;
          bcd_q  <= res_bcd_q;
          ovf_q  <= res_ovf_q;
          tmo_q  <= res_tmo_q;
          done_q <= 1'b1;
          if (cont_i) begin
            state_q     <= ST_ARM;
            cnt_start_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign done_tick_o = done_q;
  assign ovf_o       = ovf_q;
  assign tmo_o       = tmo_q;
  assign freq_o      = freq_q;
  assign bcd_o       = bcd_q;

endmodule

// File: tb/tb_multi_prd_freq_meter.sv
// Scoreboard bench: stimulus queues expected results, a monitor compares at every done_tick.
// Time base is scaled (4 clocks per tick, 100 kHz ticks, PW=12) so a timeout fits in a short run.
module tb_multi_prd_freq_meter;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         reset, start, cont, si;
  logic         ready, done_tick, ovf, tmo;
  logic [W-1:0] freq;
  logic [15:0]  bcd;

  always #5 clk = ~clk;

  multi_prd_freq_meter #(
    .CLK_HZ (400_000),
    .TICK_HZ(100_000),
    .NPRD   (4),
    .PW     (12),
    .DIGITS (4)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .cont_i     (cont),
    .si_i       (si),
    .ready_o    (ready),
    .done_tick_o(done_tick),
    .ovf_o      (ovf),
    .tmo_o      (tmo),
    .freq_o     (freq),
    .bcd_o      (bcd)
  );

  typedef struct {
    logic [W-1:0] freq;
    logic [15:0]  bcd;
    logic         ovf;
    logic         tmo;
    logic         rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   done_seen = 0;
  int   half_per  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] f, input logic [15:0] b,
                          input logic o, input logic t, input logic r);
    exp_t e;
    e.freq = f; e.bcd = b; e.ovf = o; e.tmo = t; e.rdy = r;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int s;
    s = done_seen;
    for (int i = 0; i < budget && done_seen == s; i++) @(negedge clk);
    if (done_seen == s) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"},  32'(done_tick), 32'd0);
    chk({tag, "_ovf"},   32'(ovf), 32'd0);
    chk({tag, "_tmo"},   32'(tmo), 32'd0);
    chk({tag, "_freq"},  32'(freq), 32'd0);
    chk({tag, "_bcd"},   32'(bcd), 32'd0);
  endtask

  // si generator: period is 2*half_per clocks, held low when half_per is 0.
  initial begin
    int cnt;
    cnt = 0;
    si  = 1'b0;
    forever begin
      @(negedge clk);
      if (half_per == 0) begin
        cnt = 0;
        si  = 1'b0;
      end else begin
        cnt++;
        if (cnt >= half_per) begin
          cnt = 0;
          si  = ~si;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done_tick === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done_tick actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_freq",  32'(freq),  32'(mon_e.freq));
        chk("res_bcd",   32'(bcd),   32'(mon_e.bcd));
        chk("res_ovf",   32'(ovf),   32'(mon_e.ovf));
        chk("res_tmo",   32'(tmo),   32'(mon_e.tmo));
        chk("res_ready", 32'(ready), 32'(mon_e.rdy));
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // 1 kHz: 400-clock period -> T=400 ticks -> 400000/400 = 1000
    half_per = 200;
    repeat (50) @(negedge clk);
    push_exp(19'd1000, 16'h1000, 1'b0, 1'b0, 1'b1);
    pulse_start();
    chk("ready_after_start", 32'(ready), 32'd0);
    wait_done(3000, "khz1");
    @(negedge clk);
    chk("done_one_cycle", 32'(done_tick), 32'd0);
    chk("ready_idle_khz1", 32'(ready), 32'd1);

    // 1200-clock period -> T=1200 -> 333
    half_per = 600;
    repeat (50) @(negedge clk);
    push_exp(19'd333, 16'h0333, 1'b0, 1'b0, 1'b1);
    pulse_start();
    wait_done(7000, "hz333");

    // 20-clock period -> T=20 -> 20000, saturated display
    half_per = 10;
    repeat (50) @(negedge clk);
    push_exp(19'd20000, 16'h9999, 1'b1, 1'b0, 1'b1);
    pulse_start();
    wait_done(500, "ovf");

    // si stuck low -> timeout after 4095 ticks
    half_per = 0;
    repeat (10) @(negedge clk);
    push_exp(19'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
    pulse_start();
    wait_done(17000, "tmo");
    @(negedge clk);
    chk("ready_after_tmo", 32'(ready), 32'd1);

    // continuous 500 Hz: 800-clock period -> T=800 -> 500
    half_per = 400;
    repeat (50) @(negedge clk);
    push_exp(19'd500, 16'h0500, 1'b0, 1'b0, 1'b0);
    push_exp(19'd500, 16'h0500, 1'b0, 1'b0, 1'b0);
    push_exp(19'd500, 16'h0500, 1'b0, 1'b0, 1'b1);
    cont = 1'b1;
    wait_done(5000, "cont1");
    repeat (1500) @(negedge clk);
    pulse_start();
    wait_done(5000, "cont2");
    repeat (1500) @(negedge clk);
    cont = 1'b0;
    wait_done(5000, "cont3");
    @(negedge clk);
    chk("ready_after_cont", 32'(ready), 32'd1);
    repeat (5000) @(negedge clk);
    chk("still_idle_after_cont", 32'(ready), 32'd1);

    // reset in the middle of a measurement
    half_per = 200;
    pulse_start();
    repeat (700) @(negedge clk);
    chk("busy_before_reset", 32'(ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 1'b0;
    repeat (3000) @(negedge clk);

    chk("pending_results", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
